// File: rtl/sr_pkg.sv
// rtl/sr_pkg.sv - shared types and pair encodings for the clocked SR register bank
package sr_pkg;

  typedef enum logic [1:0] {SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE} sr_prio_e;

  localparam logic [1:0] PAIR_IDLE = 2'b00;
  localparam logic [1:0] PAIR_SET  = 2'b10;
  localparam logic [1:0] PAIR_RST  = 2'b01;
  localparam logic [1:0] PAIR_BOTH = 2'b11;

endpackage

// File: rtl/sr_channel.sv
// rtl/sr_channel.sv - one filtered SR channel with change pulse; optional sticky illegal flag (SR_ILLEGAL_DETECT_EN)
module sr_channel
  import sr_pkg::*;
#(
  parameter int       FILTER_CYC = 1,
  parameter sr_prio_e PRIO       = SR_SET_DOM,
  parameter logic     INIT       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
`ifdef SR_ILLEGAL_DETECT_EN
  input  logic illegal_clr,
  output logic illegal,
`endif
  output logic q,
  output logic chg
);

  localparam int            CW      = $clog2(FILTER_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYC);

  logic [1:0]    pair;
  logic [1:0]    prev_pair_q, prev_pair_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;
  logic          chg_q, chg_d;
  logic          same;
  logic          fire;

  assign pair = {s, r};

  always_comb begin
    same        = (pair == prev_pair_q);
    prev_pair_d = pair;
    if (!same)                 cnt_d = CW'(1);
    else if (cnt_q == CNT_MAX) cnt_d = CNT_MAX;
    else                       cnt_d = cnt_q + CW'(1);
    // Fire only on the edge where the run first reaches the threshold.
    fire = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
    q_d  = q_q;
    if (fire) begin
      case (pair)
        PAIR_SET: q_d = 1'b1;
        PAIR_RST: q_d = 1'b0;
        PAIR_BOTH: begin
          case (PRIO)
            SR_SET_DOM: q_d = 1'b1;
            SR_RST_DOM: q_d = 1'b0;
            SR_TOGGLE:  q_d = ~q_q;
            default:    q_d = q_q;
          endcase
        end
        default: q_d = q_q;
      endcase
    end
    chg_d = q_d ^ q_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pair_q <= PAIR_IDLE;
      cnt_q       <= '0;
      q_q         <= INIT;
      chg_q       <= 1'b0;
    end else begin
      prev_pair_q <= prev_pair_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      chg_q       <= chg_d;
    end
  end

  assign q   = q_q;
  assign chg = chg_q;

`ifdef SR_ILLEGAL_DETECT_EN
  logic illegal_q, illegal_d;

  // Set is applied after clear so a simultaneous new violation wins.
  always_comb begin
    illegal_d = illegal_q;
    if (illegal_clr)                  illegal_d = 1'b0;
    if (fire && (pair == PAIR_BOTH)) illegal_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal = illegal_q;
`endif

endmodule

// File: rtl/sr_reg_bank.sv
// rtl/sr_reg_bank.sv - N-channel filtered SR flag bank; optional illegal-pair detect (SR_ILLEGAL_DETECT_EN)
module sr_reg_bank
  import sr_pkg::*;
#(
  parameter int           N          = 4,
  parameter int           FILTER_CYC = 1,
  parameter sr_prio_e     PRIO       = SR_SET_DOM,
  parameter logic [N-1:0] INIT       = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] s,
  input  logic [N-1:0] r,
`ifdef SR_ILLEGAL_DETECT_EN
  input  logic [N-1:0] illegal_clr,
  output logic [N-1:0] illegal,
`endif
  output logic [N-1:0] q,
  output logic [N-1:0] qb,
  output logic [N-1:0] chg
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    sr_channel #(
      .FILTER_CYC (FILTER_CYC),
      .PRIO       (PRIO),
      .INIT       (INIT[g])
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .s           (s[g]),
      .r           (r[g]),
`ifdef SR_ILLEGAL_DETECT_EN
      .illegal_clr (illegal_clr[g]),
      .illegal     (illegal[g]),
`endif
      .q           (q[g]),
      .chg         (chg[g])
    );
  end

  assign qb = ~q;

endmodule
